// File: rtl/palette_fade_ctrl_if.sv
// Pixel, palette-write and fade-control signals between the index pipeline and the palette/fader.
interface palette_fade_ctrl_if;
    logic        vsync_pulse;
    logic        pix_valid;
    logic [3:0]  pix_index;
    logic        wr_en;
    logic [3:0]  wr_index;
    logic [11:0] wr_data;
    logic        fade_start;
    logic        fade_dir;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;
    logic        pix_valid_out;
    logic        busy;
    logic        done;
    logic [4:0]  level;

    modport master (
        output vsync_pulse, pix_valid, pix_index, wr_en, wr_index, wr_data,
               fade_start, fade_dir,
        input  red, green, blue, pix_valid_out, busy, done, level
    );

    modport slave (
        input  vsync_pulse, pix_valid, pix_index, wr_en, wr_index, wr_data,
               fade_start, fade_dir,
        output red, green, blue, pix_valid_out, busy, done, level
    );
endinterface

// File: rtl/palette_fade_ctrl.sv
// 16-entry 12-bit RGB palette with a 2-stage brightness-scaled read path
// and a vsync-paced fade sequencer.
module palette_fade_ctrl #(
    parameter int FRAMES_PER_STEP = 4,
    parameter int LEVEL_MAX       = 16
) (
    input  logic                Clk,
    input  logic                Reset,
    palette_fade_ctrl_if.slave  bus
);
    localparam int FCW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [4:0]     LVL_MAX  = 5'(LEVEL_MAX);
    localparam logic [FCW-1:0] CNT_LAST = FCW'(FRAMES_PER_STEP - 1);

    typedef enum logic {IDLE, FADING} state_t;

    state_t         state_q, state_d;
    logic           dir_q, dir_d;
    logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
    logic [4:0]     level_q, level_d;
    logic           done_q, done_d;

    logic [11:0] pal_q [16];
    logic [11:0] s1_rgb_q;
    logic        s1_vld_q;
    logic [3:0]  r_q, g_q, b_q;
    logic        s2_vld_q;

    logic [4:0] req_target, cur_target, step_level;
    logic       req_at_target, step_ev;

    assign req_target    = bus.fade_dir ? LVL_MAX : 5'd0;
    assign req_at_target = (level_q == req_target);
    assign cur_target    = dir_q ? LVL_MAX : 5'd0;
    assign step_ev       = bus.vsync_pulse && (frame_cnt_q == CNT_LAST);
    assign step_level    = dir_q ? level_q + 5'd1 : level_q - 5'd1;

    // (c * level) >> 4 in 9 bits; the top nibble of the product is the scaled channel.
    function automatic logic [3:0] scale(input logic [3:0] c, input logic [4:0] lv);
        return 4'(({5'b0, c} * {4'b0, lv}) >> 4);
    endfunction

    always_ff @(posedge Clk) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (bus.fade_start && !req_at_target) state_d = FADING;
            FADING: if (step_ev && step_level == cur_target) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dir_d       = dir_q;
        frame_cnt_d = frame_cnt_q;
        level_d     = level_q;
        done_d      = 1'b0;
        unique case (state_q)
            IDLE: if (bus.fade_start) begin
                dir_d       = bus.fade_dir;
                frame_cnt_d = '0;
                done_d      = req_at_target;
            end
            FADING: if (bus.vsync_pulse) begin
                if (step_ev) begin
                    level_d     = step_level;
                    frame_cnt_d = '0;
                    done_d      = (step_level == cur_target);
                end else begin
                    frame_cnt_d = frame_cnt_q + FCW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            dir_q       <= 1'b0;
            frame_cnt_q <= '0;
            level_q     <= LVL_MAX;
            done_q      <= 1'b0;
        end else begin
            dir_q       <= dir_d;
            frame_cnt_q <= frame_cnt_d;
            level_q     <= level_d;
            done_q      <= done_d;
        end
    end

    // S1 samples the pre-write entry on a same-cycle read/write of one index.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < 16; i++) pal_q[i] <= {4'(i), 4'(i), 4'(i)};
            s1_rgb_q <= '0;
            s1_vld_q <= 1'b0;
            r_q      <= '0;
            g_q      <= '0;
            b_q      <= '0;
            s2_vld_q <= 1'b0;
        end else begin
            if (bus.wr_en) pal_q[bus.wr_index] <= bus.wr_data;
            if (bus.pix_valid) s1_rgb_q <= pal_q[bus.pix_index];
            s1_vld_q <= bus.pix_valid;
            if (s1_vld_q) begin
                r_q <= scale(s1_rgb_q[11:8], level_q);
                g_q <= scale(s1_rgb_q[7:4],  level_q);
                b_q <= scale(s1_rgb_q[3:0],  level_q);
            end
            s2_vld_q <= s1_vld_q;
        end
    end

    assign bus.red           = r_q;
    assign bus.green         = g_q;
    assign bus.blue          = b_q;
    assign bus.pix_valid_out = s2_vld_q;
    assign bus.busy          = (state_q == FADING);
    assign bus.done          = done_q;
    assign bus.level         = level_q;
endmodule

// File: tb/tb_palette_fade_ctrl.sv
// Directed bench for palette_fade_ctrl: table-driven palette lookups plus fade/reset sequences.
module tb_palette_fade_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   done_cnt = 0;
    int   base;

    palette_fade_ctrl_if bus();

    palette_fade_ctrl #(.FRAMES_PER_STEP(2), .LEVEL_MAX(16)) dut (
        .Clk(clk), .Reset(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (!rst && bus.done) done_cnt++;

    typedef struct {
        logic        we;
        logic [3:0]  wi;
        logic [11:0] wd;
        logic [3:0]  ri;
        logic [11:0] exp;
    } vec_t;
    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic rd(input logic [3:0] idx);
        bus.pix_valid = 1'b1; bus.pix_index = idx;
        @(negedge clk);
        bus.pix_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic wr(input logic [3:0] idx, input logic [11:0] d);
        bus.wr_en = 1'b1; bus.wr_index = idx; bus.wr_data = d;
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic vs(input int n);
        repeat (n) begin
            bus.vsync_pulse = 1'b1;
            @(negedge clk);
            bus.vsync_pulse = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic fstart(input logic dir);
        bus.fade_start = 1'b1; bus.fade_dir = dir;
        @(negedge clk);
        bus.fade_start = 1'b0;
    endtask

    function automatic logic [11:0] rgb();
        return {bus.red, bus.green, bus.blue};
    endfunction

    initial begin
        tbl[0] = '{1'b0, 4'd0, 12'h000, 4'd5,  12'h555};
        tbl[1] = '{1'b1, 4'd3, 12'hF80, 4'd3,  12'hF80};
        tbl[2] = '{1'b0, 4'd0, 12'h000, 4'd0,  12'h000};
        tbl[3] = '{1'b0, 4'd0, 12'h000, 4'd15, 12'hFFF};
        tbl[4] = '{1'b1, 4'd9, 12'hA5C, 4'd9,  12'hA5C};
        tbl[5] = '{1'b0, 4'd0, 12'h000, 4'd10, 12'hAAA};

        rst = 1'b1;
        bus.vsync_pulse = 0; bus.pix_valid = 0; bus.pix_index = 0;
        bus.wr_en = 0; bus.wr_index = 0; bus.wr_data = 0;
        bus.fade_start = 0; bus.fade_dir = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("reset_rgb",   rgb(), 12'h000);
        chk("reset_pvo",   bus.pix_valid_out, 1'b0);
        chk("reset_level", bus.level, 5'd16);
        chk("reset_busy",  bus.busy, 1'b0);
        chk("reset_done",  bus.done, 1'b0);

        for (int i = 0; i < 6; i++) begin
            if (tbl[i].we) wr(tbl[i].wi, tbl[i].wd);
            rd(tbl[i].ri);
            chk($sformatf("tbl%0d_rgb", i), rgb(), tbl[i].exp);
            chk($sformatf("tbl%0d_pvo", i), bus.pix_valid_out, 1'b1);
        end
        @(negedge clk);
        chk("hold_pvo", bus.pix_valid_out, 1'b0);
        chk("hold_rgb", rgb(), 12'hAAA);

        // same-cycle write+read of idx 3 sees the old entry
        bus.wr_en = 1; bus.wr_index = 3; bus.wr_data = 12'h123;
        bus.pix_valid = 1; bus.pix_index = 3;
        @(negedge clk);
        bus.wr_en = 0; bus.pix_valid = 0;
        @(negedge clk);
        chk("rw_old", rgb(), 12'hF80);
        rd(3);
        chk("rw_new", rgb(), 12'h123);
        wr(3, 12'hF80);

        // fade out, 2 frames per step
        base = done_cnt;
        fstart(1'b0);
        chk("fo_busy", bus.busy, 1'b1);
        vs(1);
        chk("fo_lvl_v1", bus.level, 5'd16);
        vs(1);
        chk("fo_lvl_v2", bus.level, 5'd15);
        vs(14);
        chk("fo_lvl_v16", bus.level, 5'd8);
        rd(3);
        chk("fo_rgb_l8", rgb(), 12'h740);
        fstart(1'b1);
        chk("fo_ign_busy", bus.busy, 1'b1);
        vs(15);
        chk("fo_lvl_v31", bus.level, 5'd1);
        chk("fo_nodone", done_cnt - base, 0);
        bus.vsync_pulse = 1'b1;
        @(negedge clk);
        bus.vsync_pulse = 1'b0;
        chk("fo_done", bus.done, 1'b1);
        chk("fo_busy_end", bus.busy, 1'b0);
        chk("fo_lvl_end", bus.level, 5'd0);
        @(negedge clk);
        chk("fo_done_drop", bus.done, 1'b0);
        chk("fo_done_once", done_cnt - base, 1);
        rd(3);
        chk("rgb_l0", rgb(), 12'h000);

        // fade back in
        base = done_cnt;
        fstart(1'b1);
        chk("fi_busy", bus.busy, 1'b1);
        vs(32);
        chk("fi_lvl", bus.level, 5'd16);
        chk("fi_busy_end", bus.busy, 1'b0);
        chk("fi_done_once", done_cnt - base, 1);
        rd(3);
        chk("fi_rgb", rgb(), 12'hF80);

        // already at target
        fstart(1'b1);
        chk("at_done", bus.done, 1'b1);
        chk("at_busy", bus.busy, 1'b0);
        chk("at_lvl",  bus.level, 5'd16);
        @(negedge clk);
        chk("at_done_drop", bus.done, 1'b0);

        // reset mid-fade
        base = done_cnt;
        fstart(1'b0);
        vs(10);
        chk("mr_lvl_pre", bus.level, 5'd11);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mr_lvl",  bus.level, 5'd16);
        chk("mr_busy", bus.busy, 1'b0);
        chk("mr_done", bus.done, 1'b0);
        rd(3);
        chk("mr_rgb", rgb(), 12'h333);
        vs(4);
        chk("mr_lvl_idle", bus.level, 5'd16);
        chk("mr_nodone", done_cnt - base, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
